// File: rtl/spi_frame_master.sv
// SPI master: sends one DATA_W-bit word per frame, MSB first, and captures
// MISO into o_rx_data at the same time. Accepts a frame via a ready/start
// handshake and pulses o_done when slave select is released.
`timescale 1ns/1ps
module spi_frame_master #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int SS_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam int GAP_W  = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((SS_GAP > 0) ? SS_GAP - 1 : 0);
  localparam logic              SCLK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic [EDGE_W-1:0]   edge_reg, edge_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [DATA_W-1:0]   tx_reg, tx_next;
  logic [DATA_W-1:0]   rx_reg, rx_next;
  logic [DATA_W-1:0]   rx_out_reg, rx_out_next;
  logic                sclk_reg, sclk_next;
  logic                mosi_reg, mosi_next;
  logic                ss_reg, ss_next;
  logic                done_reg, done_next;

  // Edge 0 of each pair is the leading edge (SCLK leaves its idle level).
  logic                leading_edge;
  assign leading_edge = ~edge_reg[0];

  assign o_ready   = (state_reg == IDLE);
  assign o_busy    = (state_reg != IDLE);
  assign o_done    = done_reg;
  assign o_rx_data = rx_out_reg;
  assign sclk      = sclk_reg;
  assign mosi      = mosi_reg;
  assign ss        = ss_reg;

  // State and datapath registers; reset takes effect immediately, even mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      div_reg    <= '0;
      edge_reg   <= '0;
      gap_reg    <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
      rx_out_reg <= '0;
      sclk_reg   <= SCLK_IDLE;
      mosi_reg   <= 1'b0;
      ss_reg     <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      edge_reg   <= edge_next;
      gap_reg    <= gap_next;
      tx_reg     <= tx_next;
      rx_reg     <= rx_next;
      rx_out_reg <= rx_out_next;
      sclk_reg   <= sclk_next;
      mosi_reg   <= mosi_next;
      ss_reg     <= ss_next;
      done_reg   <= done_next;
    end
  end

  // Next-state and next-datapath logic for the frame sequencer.
  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    edge_next   = edge_reg;
    gap_next    = gap_reg;
    tx_next     = tx_reg;
    rx_next     = rx_reg;
    rx_out_next = rx_out_reg;
    sclk_next   = sclk_reg;
    mosi_next   = mosi_reg;
    ss_next     = ss_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        div_next  = '0;
        edge_next = '0;
        if (i_start) begin
          // The word is captured here so later i_data changes cannot disturb it.
          tx_next    = i_data;
          mosi_next  = i_data[DATA_W-1];
          ss_next    = 1'b0;
          state_next = LEAD;
        end
      end

      LEAD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          state_next = SHIFT;
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end

      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next  = '0;
          sclk_next = ~sclk_reg;
          if (CPHA == 0) begin
            if (leading_edge) begin
              rx_next = {rx_reg[DATA_W-2:0], miso};
            end else if (edge_reg != EDGE_LAST) begin
              // The last trailing edge keeps the final bit on MOSI through TRAIL.
              mosi_next = tx_reg[DATA_W-2];
              tx_next   = {tx_reg[DATA_W-2:0], 1'b0};
            end
          end else begin
            if (leading_edge) begin
              // The first leading edge simply re-drives the MSB already on MOSI.
              mosi_next = tx_reg[DATA_W-1];
              tx_next   = {tx_reg[DATA_W-2:0], 1'b0};
            end else begin
              rx_next = {rx_reg[DATA_W-2:0], miso};
            end
          end
          if (edge_reg == EDGE_LAST) begin
            edge_next  = '0;
            sclk_next  = SCLK_IDLE;
            state_next = TRAIL;
          end else begin
            edge_next = edge_reg + EDGE_W'(1);
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end

      TRAIL: begin
        if (div_reg == DIV_LAST) begin
          div_next    = '0;
          gap_next    = '0;
          ss_next     = 1'b1;
          done_next   = 1'b1;
          rx_out_next = rx_reg;
          mosi_next   = 1'b0;
          state_next  = (SS_GAP == 0) ? IDLE : GAP;
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_reg == GAP_LAST) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed testbench for spi_frame_master: loopback frames, all four SPI
// modes against a slave model, ignored starts, back-to-back frames, mid-frame
// reset and a narrow fast configuration.
`timescale 1ns/1ps
module tb_spi_frame_master;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Main instance: default parameters, MISO looped back from MOSI.
  logic        i_start = 1'b0;
  logic [15:0] i_data  = '0;
  logic        o_ready, o_busy, o_done, sclk, mosi, miso, ss;
  logic [15:0] o_rx_data;

  assign miso = mosi;

  spi_frame_master u_dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_data(i_data),
    .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_rx_data(o_rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  int rise_main = 0;
  int tog_main  = 0;
  always @(posedge sclk) rise_main++;
  always @(sclk) tog_main++;

  // Narrow fast instance: 14-bit frames, one clock per half-period, loopback.
  logic        start14 = 1'b0;
  logic [13:0] data14  = '0;
  logic        ready14, busy14, done14, sclk14, mosi14, ss14;
  logic [13:0] rx14;

  spi_frame_master #(.DATA_W(14), .CLK_DIV(1)) u_dut14 (
    .clk(clk), .reset(reset), .i_start(start14), .i_data(data14),
    .o_ready(ready14), .o_busy(busy14), .o_done(done14), .o_rx_data(rx14),
    .sclk(sclk14), .mosi(mosi14), .miso(mosi14), .ss(ss14)
  );

  int rise14 = 0;
  always @(posedge sclk14) rise14++;

  // One instance per SPI mode (index = {CPOL, CPHA}), each with a slave model.
  logic        start_m = 1'b0;
  logic [15:0] data_m  = '0;
  logic        ready_m [4];
  logic        done_m  [4];
  logic        sclk_m  [4];
  logic        ss_m    [4];
  logic [15:0] rx_m    [4];
  logic [15:0] slave_rx_m [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    localparam int MP = gi / 2;
    localparam int MH = gi % 2;
    logic        m_ready, m_busy, m_done, m_sclk, m_mosi, m_ss;
    logic [15:0] m_rx;
    logic [15:0] s_word = 16'h3C5A;
    logic [15:0] s_rx = '0;
    logic        s_miso = 1'b0;
    logic        s_ss_prev = 1'b1;
    logic        s_sclk_prev = (MP != 0);
    int          s_bit = 15;

    spi_frame_master #(.CPOL(MP), .CPHA(MH)) u_mode (
      .clk(clk), .reset(reset), .i_start(start_m), .i_data(data_m),
      .o_ready(m_ready), .o_busy(m_busy), .o_done(m_done), .o_rx_data(m_rx),
      .sclk(m_sclk), .mosi(m_mosi), .miso(s_miso), .ss(m_ss)
    );

    assign ready_m[gi]    = m_ready;
    assign done_m[gi]     = m_done;
    assign sclk_m[gi]     = m_sclk;
    assign ss_m[gi]       = m_ss;
    assign rx_m[gi]       = m_rx;
    assign slave_rx_m[gi] = s_rx;

    // Slave: captures MOSI and drives s_word on MISO, MSB first, per mode.
    always @(m_ss or m_sclk) begin
      if (m_ss === 1'b0 && s_ss_prev !== 1'b0) begin
        s_rx  = '0;
        s_bit = 15;
        if (MH == 0) s_miso = s_word[15];
      end else if (m_ss === 1'b0 && m_sclk !== s_sclk_prev) begin
        if (m_sclk !== (MP != 0)) begin
          if (MH == 0) begin
            s_rx = {s_rx[14:0], m_mosi};
          end else if (s_bit >= 0) begin
            s_miso = s_word[s_bit];
          end
        end else begin
          if (MH == 0) begin
            s_bit = s_bit - 1;
            if (s_bit >= 0) s_miso = s_word[s_bit];
          end else begin
            s_rx  = {s_rx[14:0], m_mosi};
            s_bit = s_bit - 1;
          end
        end
      end
      s_ss_prev   = m_ss;
      s_sclk_prev = m_sclk;
    end
  end

  // Runs one frame on the main instance from an IDLE negedge and measures it.
  task automatic run_main_frame(input logic [15:0] d, output int ss_low, output int lat,
                                output int done_w, output int rises, output int rdy_k,
                                output logic busy_mid, output logic to);
    int  r0;
    int  cyc;
    logic seen;
    ss_low = 0; lat = 0; done_w = 0; rdy_k = 0; busy_mid = 1'b0; seen = 1'b0;
    r0 = rise_main;
    i_data  = d;
    i_start = 1'b1;
    cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        i_start = 1'b0;
        i_data  = 16'hDEAD;
      end
      if (cyc == 10) busy_mid = o_busy;
      if (ss === 1'b0) ss_low++;
      if (o_done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc;
      end
    end
    to    = !seen;
    rises = rise_main - r0;
    done_w = seen ? 1 : 0;
    cyc = 0;
    while (o_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (o_done === 1'b1) done_w++;
    end
    rdy_k = cyc + 1;
    $display("frame tx=%h rx=%h ss_low=%0d latency=%0d", d, o_rx_data, ss_low, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ss !== 1'b1) begin errors++; $display("FAIL reset_ss got=%b exp=1", ss); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx got=%h exp=0000", o_rx_data); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    $display("reset released ready=%b", o_ready);
  endtask

  task automatic test_loopback();
    int ss_low, lat, done_w, rises, rdy_k;
    logic busy_mid, to;
    run_main_frame(16'h1234, ss_low, lat, done_w, rises, rdy_k, busy_mid, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL loop_timeout got=%b exp=0", to); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL loop_rises got=%0d exp=16", rises); end
    checks++; if (ss_low !== 136) begin errors++; $display("FAIL loop_ss_low got=%0d exp=136", ss_low); end
    checks++; if (lat !== 137) begin errors++; $display("FAIL loop_latency got=%0d exp=137", lat); end
    checks++; if (done_w !== 1) begin errors++; $display("FAIL loop_done_width got=%0d exp=1", done_w); end
    checks++; if (o_rx_data !== 16'h1234) begin errors++; $display("FAIL loop_rx got=%h exp=1234", o_rx_data); end
    checks++; if (rdy_k !== 3) begin errors++; $display("FAIL loop_ready_after_done got=%0d exp=3", rdy_k); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL loop_busy_mid got=%b exp=1", busy_mid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL loop_busy_idle got=%b exp=0", o_busy); end
  endtask

  task automatic test_ignore();
    int ss_low, lat, done_w, rises, rdy_k, extra_low;
    logic busy_mid, to;
    fork
      begin
        repeat (40) @(negedge clk);
        i_start = 1'b1;
        i_data  = 16'hFFFF;
        @(negedge clk);
        i_start = 1'b0;
      end
    join_none
    run_main_frame(16'h0001, ss_low, lat, done_w, rises, rdy_k, busy_mid, to);
    checks++; if (o_rx_data !== 16'h0001) begin errors++; $display("FAIL ignore_rx got=%h exp=0001", o_rx_data); end
    checks++; if (ss_low !== 136) begin errors++; $display("FAIL ignore_ss_low got=%0d exp=136", ss_low); end
    extra_low = 0;
    repeat (30) begin
      @(negedge clk);
      if (ss !== 1'b1) extra_low++;
    end
    checks++; if (extra_low !== 0) begin errors++; $display("FAIL ignore_second_frame ss_low_cycles got=%0d exp=0", extra_low); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [15:0] rx_seen [3];
    int gaps [2];
    int n, dones, ngap, run, cyc;
    logic in_gap, prev_ss;
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
    n = 0; dones = 0; ngap = 0; run = 0; cyc = 0;
    in_gap = 1'b0; prev_ss = 1'b1;
    gaps[0] = 0; gaps[1] = 0;
    rx_seen[0] = '0; rx_seen[1] = '0; rx_seen[2] = '0;
    while (!(n == 3 && i_start == 1'b0 && dones == 3 && o_ready === 1'b1) && cyc < 1500) begin
      @(negedge clk);
      cyc++;
      if (ss === 1'b1 && prev_ss === 1'b0) begin in_gap = 1'b1; run = 0; end
      if (in_gap && ss === 1'b1) run++;
      if (in_gap && ss === 1'b0) begin
        if (ngap < 2) gaps[ngap] = run;
        ngap++;
        in_gap = 1'b0;
      end
      prev_ss = ss;
      if (o_done === 1'b1) begin
        if (dones < 3) rx_seen[dones] = o_rx_data;
        dones++;
        $display("b2b frame done rx=%h", o_rx_data);
      end
      if (o_ready === 1'b1) begin
        if (n < 3) begin
          i_start = 1'b1;
          i_data  = words[n];
          n++;
        end else begin
          i_start = 1'b0;
        end
      end else begin
        i_data = 16'hBEEF;
      end
    end
    i_start = 1'b0;
    checks++; if (cyc >= 1500) begin errors++; $display("FAIL b2b_timeout cycles got=%0d exp<1500", cyc); end
    checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
    checks++; if (rx_seen[0] !== 16'h0001) begin errors++; $display("FAIL b2b_rx0 got=%h exp=0001", rx_seen[0]); end
    checks++; if (rx_seen[1] !== 16'h0002) begin errors++; $display("FAIL b2b_rx1 got=%h exp=0002", rx_seen[1]); end
    checks++; if (rx_seen[2] !== 16'h0003) begin errors++; $display("FAIL b2b_rx2 got=%h exp=0003", rx_seen[2]); end
    checks++; if (ngap !== 2) begin errors++; $display("FAIL b2b_gap_count got=%0d exp=2", ngap); end
    checks++; if (gaps[0] !== 3) begin errors++; $display("FAIL b2b_gap0 got=%0d exp=3", gaps[0]); end
    checks++; if (gaps[1] !== 3) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=3", gaps[1]); end
  endtask

  task automatic test_reset_midframe();
    int t0, cyc;
    int ss_low, lat, done_w, rises, rdy_k;
    logic busy_mid, to;
    t0 = tog_main;
    i_data  = 16'hBEEF;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while ((tog_main - t0) < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if ((tog_main - t0) !== 7) begin errors++; $display("FAIL midreset_reach_edge7 got=%0d exp=7", tog_main - t0); end
    #2 reset = 1'b1;
    #1;
    $display("reset asserted mid-frame at sclk edge %0d", tog_main - t0);
    checks++; if (ss !== 1'b1) begin errors++; $display("FAIL midreset_ss got=%b exp=1", ss); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midreset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL midreset_mosi got=%b exp=0", mosi); end
    checks++; if (o_rx_data !== 16'h0000) begin errors++; $display("FAIL midreset_rx got=%h exp=0000", o_rx_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", o_busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", o_ready); end
    run_main_frame(16'h5A5A, ss_low, lat, done_w, rises, rdy_k, busy_mid, to);
    checks++; if (o_rx_data !== 16'h5A5A) begin errors++; $display("FAIL postreset_rx got=%h exp=5a5a", o_rx_data); end
    checks++; if (ss_low !== 136) begin errors++; $display("FAIL postreset_ss_low got=%0d exp=136", ss_low); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL postreset_rises got=%0d exp=16", rises); end
  endtask

  task automatic test_modes();
    int cyc, seen;
    logic exp_pol;
    for (int i = 0; i < 4; i++) begin
      exp_pol = (i >= 2);
      checks++; if (sclk_m[i] !== exp_pol) begin errors++; $display("FAIL mode%0d_sclk_idle_before got=%b exp=%b", i, sclk_m[i], exp_pol); end
    end
    data_m  = 16'hA5C3;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    data_m  = 16'h0000;
    cyc = 0; seen = 0;
    while (seen < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) if (done_m[i] === 1'b1) seen++;
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL modes_done_count got=%0d exp=4", seen); end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_pol = (i >= 2);
      $display("mode cpol=%0d cpha=%0d master_rx=%h slave_rx=%h", i / 2, i % 2, rx_m[i], slave_rx_m[i]);
      checks++; if (slave_rx_m[i] !== 16'hA5C3) begin errors++; $display("FAIL mode%0d_slave_rx got=%h exp=a5c3", i, slave_rx_m[i]); end
      checks++; if (rx_m[i] !== 16'h3C5A) begin errors++; $display("FAIL mode%0d_master_rx got=%h exp=3c5a", i, rx_m[i]); end
      checks++; if (sclk_m[i] !== exp_pol) begin errors++; $display("FAIL mode%0d_sclk_idle_after got=%b exp=%b", i, sclk_m[i], exp_pol); end
      checks++; if (ss_m[i] !== 1'b1) begin errors++; $display("FAIL mode%0d_ss_after got=%b exp=1", i, ss_m[i]); end
    end
  endtask

  task automatic test_narrow();
    int r0, cyc, ss_low;
    logic seen;
    r0 = rise14;
    data14  = 14'h2ABC;
    start14 = 1'b1;
    @(negedge clk);
    start14 = 1'b0;
    data14  = 14'h0000;
    cyc = 0; ss_low = 0; seen = 1'b0;
    if (ss14 === 1'b0) ss_low++;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ss14 === 1'b0) ss_low++;
      if (done14 === 1'b1) seen = 1'b1;
    end
    $display("narrow frame tx=2abc rx=%h ss_low=%0d rises=%0d", rx14, ss_low, rise14 - r0);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL narrow_timeout got=%b exp=1", seen); end
    checks++; if ((rise14 - r0) !== 14) begin errors++; $display("FAIL narrow_rises got=%0d exp=14", rise14 - r0); end
    checks++; if (ss_low !== 30) begin errors++; $display("FAIL narrow_ss_low got=%0d exp=30", ss_low); end
    checks++; if (rx14 !== 14'h2ABC) begin errors++; $display("FAIL narrow_rx got=%h exp=2abc", rx14); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ignore();
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_reset_midframe();
    repeat (5) @(negedge clk);
    test_modes();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
